btn_deb_n: RTL and testbench
============================

BTN_DEB_N -- requirements
Module: btn_deb_n

Interface
REQ-001 Parameter N, default 4: number of independent button channels, N>=1.
REQ-002 Parameter DEB_TICKS, default 4: number of consecutive ce ticks a changed input must stay stable before it is accepted, DEB_TICKS>=1.
REQ-003 Parameter LONG_TICKS, default 16: ce ticks of accepted press before long-press, LONG_TICKS>=1.
REQ-004 Parameter RPT_TICKS, default 4: ce ticks between auto-repeat pulses after long-press; 0 disables repeat.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 ce  input  1  sampling tick enable, one clk wide when high.
REQ-008 btn  input  N  raw asynchronous button levels, 1 = pressed.
REQ-009 res  output  N  debounced level per channel.
REQ-010 en  output  N  press pulse per channel, one clk wide.
REQ-011 rel  output  N  release pulse per channel, one clk wide.
REQ-012 lng  output  N  long-press pulse per channel, one clk wide.
REQ-013 rpt  output  N  auto-repeat pulse per channel, one clk wide.

Function
REQ-014 Each btn bit SHALL pass a 2-flop synchroniser clocked every clk, independent of ce; the synchronised value is s.
REQ-015 Each channel SHALL be fully independent; activity on one channel never affects another.
REQ-016 Debounce counter: on clk edge with ce=1 and s!=res, increment; with s==res, clear (regardless of ce).
REQ-017 When ce=1, s!=res and counter==DEB_TICKS-1, res SHALL take s and the counter SHALL clear on that edge.
REQ-018 A glitch lasting fewer than DEB_TICKS ce ticks SHALL produce no change on any output.
REQ-019 en SHALL be 1 for exactly the first clk cycle in which res is 1 after being 0; rel likewise for res 1->0.
REQ-020 Per-channel FSM states: IDLE (res=0), PRESSED, HELD; reset state IDLE.
REQ-021 IDLE->PRESSED on the edge res rises; hold counter cleared.
REQ-022 PRESSED: hold counter increments on ce; on ce with counter==LONG_TICKS-1, lng pulses one cycle, counter clears, go HELD.
REQ-023 HELD with RPT_TICKS>0: counter increments on ce; on ce with counter==RPT_TICKS-1, rpt pulses one cycle, counter clears; repeats while held.
REQ-024 HELD with RPT_TICKS=0: rpt SHALL stay 0; FSM remains HELD until release.
REQ-025 PRESSED or HELD -> IDLE on the edge res falls; hold counter clears.
REQ-026 If a release commits on the same edge that would issue lng or rpt, release wins: rel asserted, lng/rpt suppressed.
REQ-027 ce=0 SHALL freeze debounce and hold counters (except REQ-016 clear) and FSM timing; synchroniser keeps running.
REQ-028 All counters SHALL saturate-free by construction: width sized to the maximum of DEB_TICKS, LONG_TICKS, RPT_TICKS; no wrap is observable.
REQ-029 All outputs SHALL be registered; no combinational path from btn or ce to any output.

Reset
REQ-030 rst=1 SHALL asynchronously force res, en, rel, lng, rpt to 0, clear synchronisers and all counters, FSM to IDLE.
REQ-031 Reset asserted mid-press SHALL produce no rel pulse; after deassertion a still-held button is re-debounced and yields a fresh en.
REQ-032 First edge after rst deassertion SHALL behave as a normal edge.

Verification (N=4, DEB_TICKS=4, LONG_TICKS=16, RPT_TICKS=4, ce every 4th clk)
REQ-033 btn[0] 0->1 held 200 clk -> res[0] rises 2 clk + 4 ce ticks later (within one ce period), en[0] one clk; lng[0] 16 ticks later; rpt[0] every 4 ticks after; btn[0]->0 -> rel[0] one clk after 4 ticks, no further rpt.
REQ-034 btn[1] high 8 clk (2 ticks) then low -> res, en, rel, lng, rpt all stay 0 on every channel.
REQ-035 ce held 0 for 100 clk while btn toggles -> all outputs constant; ce resumed with btn stable -> normal debounce.
REQ-036 btn[2] and btn[3] pressed on same clk, btn[3] released after 5 ticks -> both en same cycle; rel[3] only; lng[2] alone at tick 16.
REQ-037 rst pulsed during HELD on channel 0 -> all outputs 0 immediately, no rel; btn still 1 -> new en after debounce.
REQ-038 Instance with RPT_TICKS=0, press held 300 clk -> single lng, rpt never asserted.

Source files
------------

// File: rtl/btn_deb_n_if.sv
// Button debouncer bus: tick enable and raw levels in, debounced level and
// event pulses out. One bit per channel on every vector.
//   ce  : sampling tick enable, one clk wide
//   btn : raw asynchronous button levels, 1 = pressed
//   res : debounced level
//   en  : press pulse        rel : release pulse
//   lng : long-press pulse   rpt : auto-repeat pulse
// master = stimulus side, slave = debouncer side.
interface btn_deb_n_if #(
  parameter int unsigned N = 4
);
  logic         ce;
  logic [N-1:0] btn;
  logic [N-1:0] res;
  logic [N-1:0] en;
  logic [N-1:0] rel;
  logic [N-1:0] lng;
  logic [N-1:0] rpt;

  modport master (
    output ce, btn,
    input  res, en, rel, lng, rpt
  );

  modport slave (
    input  ce, btn,
    output res, en, rel, lng, rpt
  );
endinterface

// File: rtl/btn_deb_n.sv
// N-channel button debouncer with press/release/long-press/auto-repeat events.
// Ports:
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : btn_deb_n_if.slave (ce, btn in; res, en, rel, lng, rpt out)
// Each channel: 2-flop synchroniser -> ce-paced debounce counter -> level res,
// then a small IDLE/PRESSED/HELD FSM timing long-press and repeat in ce ticks.
// Every output is a flop; channels share nothing but clk, rst and ce.
module btn_deb_n #(
  parameter int unsigned N          = 4,
  parameter int unsigned DEB_TICKS  = 4,
  parameter int unsigned LONG_TICKS = 16,
  parameter int unsigned RPT_TICKS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  btn_deb_n_if.slave bus
);

  // One counter width covers every terminal count, so no count can wrap.
  localparam int unsigned MAX_DL    = (DEB_TICKS > LONG_TICKS) ? DEB_TICKS : LONG_TICKS;
  localparam int unsigned MAX_T     = (MAX_DL > RPT_TICKS) ? MAX_DL : RPT_TICKS;
  localparam int unsigned CW        = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int unsigned DEB_LAST  = DEB_TICKS - 1;
  localparam int unsigned LONG_LAST = LONG_TICKS - 1;
  localparam int unsigned RPT_LAST  = (RPT_TICKS > 0) ? RPT_TICKS - 1 : 0;
  localparam bit          RPT_ON    = (RPT_TICKS > 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  logic [N-1:0] res_v;
  logic [N-1:0] en_v;
  logic [N-1:0] rel_v;
  logic [N-1:0] lng_v;
  logic [N-1:0] rpt_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic          s1_q;
    logic          s2_q;
    logic          res_q;
    logic          res_d;
    logic [CW-1:0] dcnt_q;
    logic [CW-1:0] dcnt_d;
    logic          commit;
    logic          rise;
    logic          fall;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] hcnt_q;
    logic [CW-1:0] hcnt_d;
    logic          en_q;
    logic          rel_q;
    logic          lng_q;
    logic          lng_d;
    logic          rpt_q;
    logic          rpt_d;

    // Synchroniser runs every clk, independent of ce.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= bus.btn[i];
        s2_q <= s1_q;
      end
    end

    // Debounce: count ce ticks of disagreement, clear on any agreement.
    always_comb begin
      res_d  = res_q;
      dcnt_d = dcnt_q;
      commit = 1'b0;
      if (s2_q == res_q) begin
        dcnt_d = '0;
      end else if (bus.ce) begin
        if (dcnt_q == CW'(DEB_LAST)) begin
          res_d  = s2_q;
          dcnt_d = '0;
          commit = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CW'(1);
        end
      end
    end

    assign rise = commit & s2_q;
    assign fall = commit & ~s2_q;

    // Hold FSM next state; a committing release pre-empts lng/rpt on the same edge.
    always_comb begin
      state_d = state_q;
      hcnt_d  = hcnt_q;
      lng_d   = 1'b0;
      rpt_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d = ST_PRESSED;
            hcnt_d  = '0;
          end
        end
        ST_PRESSED: begin
          if (fall) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end else if (bus.ce) begin
            if (hcnt_q == CW'(LONG_LAST)) begin
              lng_d   = 1'b1;
              hcnt_d  = '0;
              state_d = ST_HELD;
            end else begin
              hcnt_d = hcnt_q + CW'(1);
            end
          end
        end
        ST_HELD: begin
          if (fall) begin
            state_d = ST_IDLE;
            hcnt_d  = '0;
          end else if (bus.ce && RPT_ON) begin
            if (hcnt_q == CW'(RPT_LAST)) begin
              rpt_d  = 1'b1;
              hcnt_d = '0;
            end else begin
              hcnt_d = hcnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          hcnt_d  = '0;
        end
      endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        res_q   <= 1'b0;
        dcnt_q  <= '0;
        state_q <= ST_IDLE;
        hcnt_q  <= '0;
        en_q    <= 1'b0;
        rel_q   <= 1'b0;
        lng_q   <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        res_q   <= res_d;
        dcnt_q  <= dcnt_d;
        state_q <= state_d;
        hcnt_q  <= hcnt_d;
        en_q    <= rise;
        rel_q   <= fall;
        lng_q   <= lng_d;
        rpt_q   <= rpt_d;
      end
    end

    assign res_v[i] = res_q;
    assign en_v[i]  = en_q;
    assign rel_v[i] = rel_q;
    assign lng_v[i] = lng_q;
    assign rpt_v[i] = rpt_q;
  end

  assign bus.res = res_v;
  assign bus.en  = en_v;
  assign bus.rel = rel_v;
  assign bus.lng = lng_v;
  assign bus.rpt = rpt_v;

endmodule

// File: tb/tb_btn_deb_n.sv
// Directed bench for btn_deb_n: a 4-channel repeat instance and a 1-channel
// no-repeat instance. Expected pulses (instance, channel, kind, clk edge) are
// queued when stimulus is applied; a negedge monitor matches every observed
// pulse against the queue.
module tb_btn_deb_n;

  localparam int DEB  = 4;
  localparam int LONG = 16;
  localparam int RPT  = 4;
  localparam int CEP  = 4;

  localparam int K_EN  = 0;
  localparam int K_REL = 1;
  localparam int K_LNG = 2;
  localparam int K_RPT = 3;

  typedef struct {
    int dut;
    int ch;
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  bit   ce_on;
  int   total = 0;
  int   bad = 0;
  ev_t  exp_q[$];
  string kname[4] = '{"en", "rel", "lng", "rpt"};

  btn_deb_n_if #(.N(4)) ifa ();
  btn_deb_n_if #(.N(1)) ifb ();

  btn_deb_n #(.N(4), .DEB_TICKS(DEB), .LONG_TICKS(LONG), .RPT_TICKS(RPT)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  btn_deb_n #(.N(1), .DEB_TICKS(DEB), .LONG_TICKS(LONG), .RPT_TICKS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic push_ev(int d, int c, int k, int at);
    ev_t e;
    e.dut = d; e.ch = c; e.kind = k; e.at = at;
    exp_q.push_back(e);
  endtask

  // Advance n edges; ce for the coming edge e is high when e is a multiple of 4.
  task automatic clk_n(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ifa.ce = ce_on && (((cyc + 1) % CEP) == 0);
      ifb.ce = ifa.ce;
    end
  endtask

  task automatic run_to(int e);
    while (cyc < e) clk_n(1);
  endtask

  // Commit edge: DEB-th ce edge counted from edge 'from' (s visible 2 edges after btn).
  function automatic int deb_commit(int from);
    int e = from;
    while ((e % CEP) != 0) e++;
    return e + CEP * (DEB - 1);
  endfunction

  function automatic logic pulse(int d, int c, int k);
    logic [3:0] v;
    if (d == 0) begin
      case (k)
        K_EN:    v = ifa.en;
        K_REL:   v = ifa.rel;
        K_LNG:   v = ifa.lng;
        default: v = ifa.rpt;
      endcase
    end else begin
      case (k)
        K_EN:    v = {3'b000, ifb.en};
        K_REL:   v = {3'b000, ifb.rel};
        K_LNG:   v = {3'b000, ifb.lng};
        default: v = {3'b000, ifb.rpt};
      endcase
    end
    return v[c] === 1'b1;
  endfunction

  task automatic see(int d, int c, int k);
    int idx = -1;
    foreach (exp_q[j])
      if (idx < 0 && exp_q[j].dut == d && exp_q[j].ch == c && exp_q[j].kind == k) idx = j;
    total++;
    assert (idx >= 0) else begin
      bad++;
      $error("FAIL unexpected_%s dut%0d ch%0d: observed pulse at edge %0d, expected none",
             kname[k], d, c, cyc);
    end
    if (idx >= 0) begin
      total++;
      assert (cyc === exp_q[idx].at) else begin
        bad++;
        $error("FAIL timing_%s dut%0d ch%0d: observed edge %0d expected edge %0d",
               kname[k], d, c, cyc, exp_q[idx].at);
      end
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++)
        for (int k = 0; k < 4; k++) begin
          if (d == 1 && c > 0) continue;
          if (pulse(d, c, k)) see(d, c, k);
        end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, c, x, q, r, cr, c2;
    rst = 1'b1;
    ce_on = 1'b0;
    ifa.ce = 1'b0; ifa.btn = '0;
    ifb.ce = 1'b0; ifb.btn = '0;

    // Reset state
    clk_n(3);
    chk("rst_res_a", 32'(ifa.res), 0);
    chk("rst_pulses_a", 32'({ifa.en, ifa.rel, ifa.lng, ifa.rpt}), 0);
    chk("rst_res_b", 32'(ifb.res), 0);
    rst = 1'b0;
    ce_on = 1'b1;
    clk_n(4);
    chk("post_rst_res_a", 32'(ifa.res), 0);

    // Press ch0: en, long-press, repeats; release lands on a repeat edge
    p = cyc;
    ifa.btn[0] = 1'b1;
    c = deb_commit(p + 3);
    push_ev(0, 0, K_EN, c);
    push_ev(0, 0, K_LNG, c + CEP * LONG);
    for (int k = 0; k < 6; k++) push_ev(0, 0, K_RPT, c + CEP * LONG + CEP * RPT * (k + 1));
    run_to(c - 1);
    chk("a_res_before", 32'(ifa.res[0]), 0);
    clk_n(1);
    chk("a_res_after", 32'(ifa.res[0]), 1);
    x = c + CEP * LONG + CEP * RPT * 7;
    run_to(x - 15);
    ifa.btn[0] = 1'b0;
    push_ev(0, 0, K_REL, x);
    run_to(x - 1);
    chk("a_res_held", 32'(ifa.res[0]), 1);
    clk_n(1);
    chk("a_res_released", 32'(ifa.res[0]), 0);
    clk_n(60);
    chk("a_queue", 32'(exp_q.size()), 0);

    // Glitch of 2 ce ticks on ch1
    ifa.btn[1] = 1'b1;
    clk_n(8);
    ifa.btn[1] = 1'b0;
    clk_n(40);
    chk("b_res", 32'(ifa.res), 0);
    chk("b_queue", 32'(exp_q.size()), 0);

    // ce frozen while btn toggles, then resumed with stable btn
    ce_on = 1'b0;
    clk_n(1);
    for (int i = 0; i < 100; i++) begin
      ifa.btn = 4'($urandom);
      clk_n(1);
      chk("c_res_frozen", 32'(ifa.res), 0);
    end
    ifa.btn = 4'b0010;
    clk_n(5);
    ce_on = 1'b1;
    q = cyc;
    c = deb_commit(q + 1);
    push_ev(0, 1, K_EN, c);
    run_to(c - 1);
    chk("c_res_before", 32'(ifa.res), 0);
    clk_n(1);
    chk("c_res_after", 32'(ifa.res), 32'h2);
    r = cyc;
    ifa.btn = 4'b0000;
    cr = deb_commit(r + 3);
    push_ev(0, 1, K_REL, cr);
    run_to(cr + 4);
    chk("c_queue", 32'(exp_q.size()), 0);
    chk("c_res_end", 32'(ifa.res), 0);

    // ch2 and ch3 pressed together; ch3 released early
    p = cyc;
    ifa.btn = 4'b1100;
    c = deb_commit(p + 3);
    push_ev(0, 2, K_EN, c);
    push_ev(0, 3, K_EN, c);
    run_to(c + CEP * 5);
    ifa.btn[3] = 1'b0;
    push_ev(0, 3, K_REL, deb_commit(cyc + 3));
    push_ev(0, 2, K_LNG, c + CEP * LONG);
    run_to(c + CEP * LONG - 1);
    chk("d_res_mid", 32'(ifa.res), 32'h4);
    run_to(c + CEP * LONG + 6);
    ifa.btn[2] = 1'b0;
    push_ev(0, 2, K_RPT, c + CEP * LONG + CEP * RPT);
    push_ev(0, 2, K_REL, deb_commit(cyc + 3));
    run_to(c + CEP * LONG + 32);
    chk("d_queue", 32'(exp_q.size()), 0);
    chk("d_res_end", 32'(ifa.res), 0);

    // Reset during HELD on ch0: no rel, fresh en after re-debounce
    p = cyc;
    ifa.btn[0] = 1'b1;
    c = deb_commit(p + 3);
    push_ev(0, 0, K_EN, c);
    push_ev(0, 0, K_LNG, c + CEP * LONG);
    run_to(c + CEP * LONG + 6);
    chk("e_res_held", 32'(ifa.res[0]), 1);
    rst = 1'b1;
    #1;
    chk("e_rst_res", 32'(ifa.res), 0);
    chk("e_rst_pulses", 32'({ifa.en, ifa.rel, ifa.lng, ifa.rpt}), 0);
    clk_n(2);
    rst = 1'b0;
    q = cyc;
    c2 = deb_commit(q + 3);
    push_ev(0, 0, K_EN, c2);
    run_to(c2 - 1);
    chk("e_res_redeb_before", 32'(ifa.res[0]), 0);
    clk_n(1);
    chk("e_res_redeb_after", 32'(ifa.res[0]), 1);
    ifa.btn[0] = 1'b0;
    cr = deb_commit(cyc + 3);
    push_ev(0, 0, K_REL, cr);
    run_to(cr + 4);
    chk("e_queue", 32'(exp_q.size()), 0);

    // No-repeat instance held 300 clk: single lng, never rpt
    p = cyc;
    ifb.btn = 1'b1;
    c = deb_commit(p + 3);
    push_ev(1, 0, K_EN, c);
    push_ev(1, 0, K_LNG, c + CEP * LONG);
    run_to(p + 300);
    ifb.btn = 1'b0;
    cr = deb_commit(cyc + 3);
    push_ev(1, 0, K_REL, cr);
    run_to(cr - 1);
    chk("f_res_held", 32'(ifb.res), 1);
    clk_n(1);
    chk("f_res_released", 32'(ifb.res), 0);
    clk_n(8);
    chk("f_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
